// File: rtl/cpu_trace_pkg.sv
// Shared state encoding and entry layout for the CPU trace buffer.
// Defining TRACE_CYCLE_STAMP_EN prepends a cycle stamp to every stored entry.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } trace_state_t;

`ifdef TRACE_CYCLE_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

  // Entry layout, LSB first: instr, pc, then the optional stamp.
  localparam int INSTR_LSB = 0;

  function automatic int pc_lsb(input int instr_w);
    return INSTR_LSB + instr_w;
  endfunction

  function automatic int stamp_lsb(input int pc_w, input int instr_w);
    return pc_lsb(instr_w) + pc_w;
  endfunction

  function automatic int entry_width(input int stamp_w, input int pc_w, input int instr_w);
    return stamp_lsb(pc_w, instr_w) + (STAMP_EN ? stamp_w : 0);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port and one registered read port whose output
// holds its value until the next read.
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU instruction trace buffer: captures {pc, instr} each cycle of a run and
// drains oldest-first afterwards. Cycle stamps are enabled by TRACE_CYCLE_STAMP_EN.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int RUN_CYCLES = 130,
  parameter int WRAP       = 0,
  parameter int STAMP_W    = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [PC_W-1:0]                             pc,
  input  logic [INSTR_W-1:0]                          instr,
  input  logic [PC_W-1:0]                             stop_pc,
  input  logic                                        stop_pc_en,
  input  logic                                        rd_en,
  output logic [entry_width(STAMP_W, PC_W, INSTR_W)-1:0] rd_data,
  output logic                                        rd_valid,
  output logic [$clog2(DEPTH):0]                      count,
  output logic [1:0]                                  state,
  output logic                                        overflow
);

  localparam int ENTRY_W = entry_width(STAMP_W, PC_W, INSTR_W);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(RUN_CYCLES + 1);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(RUN_CYCLES);
  localparam logic [CW-1:0] LAST_M1 = CW'(RUN_CYCLES - 1);

  trace_state_t  st;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [CW-1:0] cyc;
  logic          ovf, rvalid;

  logic               full, stop_hit, budget_hit, cap_write, pop;
  logic [ENTRY_W-1:0] wdata;

  assign full       = (cnt == FULL);
  assign stop_hit   = stop_pc_en && (pc == stop_pc);
  assign budget_hit = (cyc == LAST_M1);
  assign cap_write  = (st == ST_CAPTURE) && (!full || (WRAP != 0));
  // A restart takes priority over a pop issued in the same cycle.
  assign pop        = (st == ST_DONE) && rd_en && (cnt != '0) && !start;

  generate
    if (STAMP_EN) begin : g_stamp
      assign wdata = {STAMP_W'(cyc), pc, instr};
    end else begin : g_plain
      assign wdata = {pc, instr};
    end
  endgenerate

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (cap_write),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Run control, pointer bookkeeping and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      cyc    <= '0;
      ovf    <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= pop;
      case (st)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            st     <= ST_CAPTURE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            cyc    <= '0;
            ovf    <= 1'b0;
          end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            cnt    <= cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (cyc != LAST) cyc <= cyc + 1'b1;
          if (!full) begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
          end else begin
            // When full, circular mode overwrites the oldest entry.
            ovf <= 1'b1;
            if (WRAP != 0) begin
              wr_ptr <= wr_ptr + 1'b1;
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
          if (budget_hit || stop_hit) st <= ST_DONE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state    = st;
  assign count    = cnt;
  assign overflow = ovf;
  assign rd_valid = rvalid;

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, trace entries held; power of two, at least 2.
REQ-002 SHALL have parameter PC_W, default 32, width of the captured program counter.
REQ-003 SHALL have parameter INSTR_W, default 32, width of the captured instruction.
REQ-004 SHALL have parameter RUN_CYCLES, default 130, maximum capture cycles per run.
REQ-005 SHALL have parameter WRAP, default 0: 0 = keep first DEPTH entries; 1 = circular, keep last DEPTH entries.
REQ-006 SHALL have parameter STAMP_W, default 16, cycle-stamp width (used only under REQ-027).
REQ-007 SHALL have ports:
 clk  in  1  single clock, all state on rising edge
 reset  in  1  asynchronous, active-high
 start  in  1  single-cycle arm/restart pulse
 pc  in  PC_W  CPU program counter
 instr  in  INSTR_W  CPU current instruction
 stop_pc  in  PC_W  capture-stop address
 stop_pc_en  in  1  enables stop_pc match
 rd_en  in  1  pop oldest entry
 rd_data  out  ENTRY_W  popped entry, {pc, instr} (stamp MSBs when enabled)
 rd_valid  out  1  rd_data valid this cycle
 count  out  clog2(DEPTH)+1  entries held
 state  out  2  IDLE=0, CAPTURE=1, DONE=2
 overflow  out  1  sticky: an entry was dropped or overwritten

Function
REQ-008 SHALL implement states IDLE, CAPTURE, DONE.
REQ-009 IDLE: start -> CAPTURE next cycle, clearing pointers, count, cycle counter, overflow.
REQ-010 CAPTURE: every cycle SHALL record {pc, instr} sampled that edge and increment the cycle counter.
REQ-011 WRAP=0, full: further samples SHALL be discarded, overflow set, count held at DEPTH.
REQ-012 WRAP=1, full: newest SHALL overwrite oldest, read pointer advances, overflow set, count held at DEPTH.
REQ-013 CAPTURE -> DONE after the cycle in which cycle counter reaches RUN_CYCLES; that cycle's sample is recorded.
REQ-014 CAPTURE -> DONE after a cycle with stop_pc_en=1 and pc==stop_pc; matching sample is recorded.
REQ-015 Budget expiry and stop match in the same cycle SHALL give a single DONE transition, sample recorded once.
REQ-016 DONE: rd_en with count>0 SHALL output oldest entry on rd_data with rd_valid high the following cycle, decrement count; one-cycle latency.
REQ-017 rd_en with count=0, or in IDLE/CAPTURE, SHALL be ignored; rd_valid low.
REQ-018 rd_valid SHALL be high only the cycle after an accepted pop; rd_data holds last value otherwise.
REQ-019 start in CAPTURE SHALL be ignored; start in DONE SHALL restart as REQ-009, discarding unread entries.
REQ-020 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-021 Cycle counter SHALL saturate at RUN_CYCLES, never wrap.

Reset
REQ-022 reset SHALL asynchronously force state=IDLE, count=0, rd_valid=0, rd_data=0, overflow=0, pointers and cycle counter 0.
REQ-023 reset mid-CAPTURE or mid-drain SHALL discard all entries; storage contents need not be cleared.
REQ-024 First start after reset deassertion SHALL be honoured.

Configuration
REQ-025 Macro TRACE_CYCLE_STAMP_EN SHALL select the cycle-stamp feature.
REQ-026 Without it, ENTRY_W = PC_W+INSTR_W.
REQ-027 With it, ENTRY_W = STAMP_W+PC_W+INSTR_W; each entry carries cycle-counter value (0 for first capture cycle) in its MSBs, truncated to STAMP_W.

Structure
REQ-028 State encodings and entry field offsets SHALL live in shared package cpu_trace_pkg.
REQ-029 Storage SHALL be sub-module trace_ram (DEPTH x ENTRY_W, one write port, one registered read port).

Verification
REQ-030 Defaults, start, pc 0,4,8,... for 130 cycles -> DONE at cycle 130, count=32, overflow=1, pops return pc 0..124.
REQ-031 WRAP=1, same stimulus -> pops return pc 392..516 in order, overflow=1.
REQ-032 stop_pc=0x20, stop_pc_en=1 -> DONE after pc 0x20 captured, count=9, overflow=0.
REQ-033 DONE with count=0, rd_en high 3 cycles -> rd_valid stays 0, count stays 0.
REQ-034 reset asserted mid-CAPTURE at cycle 10 -> immediately state=0, count=0; new start captures from pc at that time.
REQ-035 TRACE_CYCLE_STAMP_EN defined, 5 captured cycles -> stamps 0,1,2,3,4.
